ps2_move_source: RTL and testbench
==================================

PS2_MOVE_SOURCE -- requirements
Module: ps2_move_source

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 5000, is the maximum number of clk cycles allowed between ps2_clk falling edges within one frame (100 us at 50 MHz).
REQ-002 Port clk, input, 1 bit: the only system clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port ps2_clk, input, 1 bit: raw keyboard clock, asynchronous to clk.
REQ-005 Port ps2_dat, input, 1 bit: raw keyboard data, asynchronous to clk.
REQ-006 Port key_ascii, output, 8 bits: ASCII code of the last counted key (97 a, 100 d, 119 w, 115 s); feeds ps2_out of the move parser.
REQ-007 Port key_count, output, 8 bits: press count of the key in key_ascii; feeds dataReg of the move parser.
REQ-008 Port key_valid, output, 1 bit: one-cycle strobe indicating key_ascii/key_count were updated.
REQ-009 Port frame_err, output, 1 bit: one-cycle strobe on a parity, start, stop or timeout error.

Function
REQ-010 ps2_clk and ps2_dat SHALL each pass through a 2-flop synchronizer; a falling edge is detected from the synchronized clock (third flop), adding 3 clk cycles of latency.
REQ-011 Receive FSM SHALL have states IDLE, DATA, PARITY, STOP; transitions occur only on detected falling edges, except timeout.
REQ-012 IDLE: on a falling edge, sample ps2_dat; 0 -> DATA with bit counter = 0; 1 -> pulse frame_err and stay in IDLE.
REQ-013 DATA: shift in 8 bits LSB first; after the 8th bit -> PARITY.
REQ-014 PARITY: the sampled bit SHALL make the total count of ones across the 9 bits odd; a mismatch sets an internal error flag; -> STOP.
REQ-015 STOP: the sampled bit must be 1; then -> IDLE; the byte is accepted only if the stop bit is 1 and the parity flag is clear, otherwise frame_err pulses and the byte is dropped.
REQ-016 In any non-IDLE state, TIMEOUT_CYCLES clk cycles without a falling edge SHALL force IDLE and pulse frame_err; the timeout counter resets on every falling edge.
REQ-017 Byte decode: 0xF0 sets break_pending; 0xE0 sets ext_pending; neither produces output.
REQ-018 Any other byte consumes and clears break_pending and ext_pending; bytes with ext_pending set are ignored.
REQ-019 Mapping: 0x1C->97, 0x23->100, 0x1D->119, 0x1B->115; unmapped codes are ignored.
REQ-020 Each mapped key SHALL have a held flag. A make code with held=0 sets held and increments that key's 8-bit counter, saturating at 255. A make code with held=1 (typematic repeat) is ignored. A break code clears held without counting.
REQ-021 On a counted make, key_ascii and key_count SHALL update and key_valid SHALL pulse in the clk cycle after STOP accepts the byte; outputs hold between updates.
REQ-022 Counters are monotonic non-decreasing between resets, as required by the downstream greater-than comparison.
REQ-023 Frame reception SHALL continue while key_valid is asserted; there is no backpressure.

Reset
REQ-024 While rst_n=0: FSM=IDLE; shift register, bit counter and timeout counter = 0; synchronizers = 1; break_pending, ext_pending and held flags = 0; all key counters = 0; key_ascii=0, key_count=0, key_valid=0, frame_err=0.
REQ-025 Reset asserted mid-frame SHALL discard the partial frame; the first frame fully received after release decodes correctly.

Structure
REQ-026 Shared package SHALL hold the FSM state enum, scan-code constants (0x1C, 0x23, 0x1D, 0x1B, 0xF0, 0xE0), ASCII constants (97, 100, 119, 115) and the default TIMEOUT_CYCLES.
REQ-027 One sub-module, ps2_frame_rx (synchronizer, FSM, timeout, parity), SHALL output byte and byte_ok/byte_err strobes; the top SHALL hold decode, held flags and counters.

Verification
REQ-028 Frame 0x1C, good parity -> key_valid one cycle after stop; key_ascii=97, key_count=1.
REQ-029 Sequence 0x23, 0x23, 0x23, F0 23, 0x23 -> two key_valid pulses, key_count 1 then 2, key_ascii=100.
REQ-030 Frame 0x1D with parity bit inverted -> frame_err pulses once, no key_valid, outputs unchanged.
REQ-031 Send 5 bits of a frame, then idle for TIMEOUT_CYCLES+1 -> frame_err pulses, FSM returns to IDLE; next frame 0x1B gives key_ascii=115, key_count=1.
REQ-032 256 press/release cycles of 0x1C -> key_count reaches 255 and stays 255; E0 1C gives no output.
REQ-033 Pull rst_n low mid-frame after 0x1C was counted -> all outputs 0; the next 0x1C frame gives key_count=1.

Source files
------------

// File: rtl/ps2_move_source_pkg.sv
// Shared types and constants for the PS/2 movement-key source.
// Scan-code/ASCII tables and the receive FSM state encoding live here.
package ps2_move_source_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_e;

  localparam int TIMEOUT_DEFAULT = 5000;
  localparam int NUM_KEYS        = 4;

  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  localparam logic [7:0] ASCII_A = 8'd97;
  localparam logic [7:0] ASCII_D = 8'd100;
  localparam logic [7:0] ASCII_W = 8'd119;
  localparam logic [7:0] ASCII_S = 8'd115;

  function automatic logic key_hit(input logic [7:0] code);
    return (code == SC_A) || (code == SC_D) || (code == SC_W) || (code == SC_S);
  endfunction

  function automatic logic [1:0] key_index(input logic [7:0] code);
    logic [1:0] idx;
    case (code)
      SC_A:    idx = 2'd0;
      SC_D:    idx = 2'd1;
      SC_W:    idx = 2'd2;
      SC_S:    idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  function automatic logic [7:0] key_to_ascii(input logic [1:0] idx);
    logic [7:0] a;
    case (idx)
      2'd0:    a = ASCII_A;
      2'd1:    a = ASCII_D;
      2'd2:    a = ASCII_W;
      default: a = ASCII_S;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/ps2_move_source_frame_rx.sv
// PS/2 frame receiver: line synchronizers, falling-edge detect, 11-bit frame FSM
// with odd-parity check and inter-edge timeout. byte_ok/byte_err are single-cycle strobes.
//
// state     | meaning
// ST_IDLE   | waiting for a start bit (0) on a ps2_clk falling edge
// ST_DATA   | shifting in 8 data bits, LSB first
// ST_PARITY | sampling the odd-parity bit
// ST_STOP   | sampling the stop bit, then accept or reject the byte
module ps2_frame_rx
  import ps2_move_source_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] byte_data,
  output logic       byte_ok,
  output logic       byte_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);

  logic [2:0]    clk_sync_q, clk_sync_d;
  logic [1:0]    dat_sync_q, dat_sync_d;
  rx_state_e     state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_err_q, par_err_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic fall;
  logic bit_in;

  // [1] is the synchronized clock, [2] its delayed copy for edge detection
  assign fall      = clk_sync_q[2] & ~clk_sync_q[1];
  assign bit_in    = dat_sync_q[1];
  assign byte_data = shift_q;

  always_comb begin
    clk_sync_d = {clk_sync_q[1:0], ps2_clk};
    dat_sync_d = {dat_sync_q[0], ps2_dat};
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_err_d  = par_err_q;
    tmo_d      = tmo_q;
    byte_ok    = 1'b0;
    byte_err   = 1'b0;

    if (state_q != ST_IDLE) begin
      if (fall) begin
        tmo_d = TMO_LOAD;
      end else if (tmo_q == '0) begin
        state_d  = ST_IDLE;
        byte_err = 1'b1;
      end else begin
        tmo_d = tmo_q - TW'(1);
      end
    end

    if (fall) begin
      case (state_q)
        ST_IDLE: begin
          if (!bit_in) begin
            state_d   = ST_DATA;
            bit_cnt_d = 3'd0;
            par_err_d = 1'b0;
            tmo_d     = TMO_LOAD;
          end else begin
            byte_err = 1'b1;
          end
        end
        ST_DATA: begin
          shift_d   = {bit_in, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          par_err_d = ~(^{shift_q, bit_in});
          state_d   = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (bit_in && !par_err_q) byte_ok  = 1'b1;
          else                      byte_err = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q <= 3'b111;
      dat_sync_q <= 2'b11;
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'd0;
      par_err_q  <= 1'b0;
      tmo_q      <= '0;
    end else begin
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_err_q  <= par_err_d;
      tmo_q      <= tmo_d;
    end
  end

endmodule

// File: rtl/ps2_move_source.sv
// PS/2 movement-key source: decodes received bytes into per-key press counts
// for the WASD move parser, ignoring typematic repeats and extended codes.
module ps2_move_source
  import ps2_move_source_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] key_ascii,
  output logic [7:0] key_count,
  output logic       key_valid,
  output logic       frame_err
);

  logic [7:0] rx_byte;
  logic       rx_ok;
  logic       rx_err;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .ps2_clk  (ps2_clk),
    .ps2_dat  (ps2_dat),
    .byte_data(rx_byte),
    .byte_ok  (rx_ok),
    .byte_err (rx_err)
  );

  logic                     brk_q, brk_d;
  logic                     ext_q, ext_d;
  logic [NUM_KEYS-1:0]      held_q, held_d;
  logic [NUM_KEYS-1:0][7:0] cnt_q, cnt_d;
  logic [7:0]               key_ascii_q, key_ascii_d;
  logic [7:0]               key_count_q, key_count_d;
  logic                     key_valid_q, key_valid_d;
  logic                     frame_err_q, frame_err_d;

  logic       hit;
  logic [1:0] idx;
  logic [7:0] cnt_next;

  assign hit      = key_hit(rx_byte);
  assign idx      = key_index(rx_byte);
  assign cnt_next = (cnt_q[idx] == 8'hFF) ? 8'hFF : cnt_q[idx] + 8'd1;

  always_comb begin
    brk_d       = brk_q;
    ext_d       = ext_q;
    held_d      = held_q;
    cnt_d       = cnt_q;
    key_ascii_d = key_ascii_q;
    key_count_d = key_count_q;
    key_valid_d = 1'b0;
    frame_err_d = rx_err;

    if (rx_ok) begin
      if (rx_byte == SC_BREAK) begin
        brk_d = 1'b1;
      end else if (rx_byte == SC_EXT) begin
        ext_d = 1'b1;
      end else begin
        brk_d = 1'b0;
        ext_d = 1'b0;
        if (!ext_q && hit) begin
          if (brk_q) begin
            held_d[idx] = 1'b0;
          end else if (!held_q[idx]) begin
            // Only the first make of a hold counts; typematic repeats fall through
            held_d[idx] = 1'b1;
            cnt_d[idx]  = cnt_next;
            key_ascii_d = key_to_ascii(idx);
            key_count_d = cnt_next;
            key_valid_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      brk_q       <= 1'b0;
      ext_q       <= 1'b0;
      held_q      <= '0;
      cnt_q       <= '0;
      key_ascii_q <= 8'd0;
      key_count_q <= 8'd0;
      key_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      brk_q       <= brk_d;
      ext_q       <= ext_d;
      held_q      <= held_d;
      cnt_q       <= cnt_d;
      key_ascii_q <= key_ascii_d;
      key_count_q <= key_count_d;
      key_valid_q <= key_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign key_ascii = key_ascii_q;
  assign key_count = key_count_q;
  assign key_valid = key_valid_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_move_source.sv
// Scoreboard bench for ps2_move_source: a byte-level keyboard model queues the
// expected key/error events and a monitor checks every strobe the DUT produces.
module tb_ps2_move_source;

  localparam int TMO  = 100;
  localparam int HALF = 3;

  logic       clk;
  logic       rst_n;
  logic       ps2_clk;
  logic       ps2_dat;
  logic [7:0] key_ascii;
  logic [7:0] key_count;
  logic       key_valid;
  logic       frame_err;

  ps2_move_source #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ps2_clk  (ps2_clk),
    .ps2_dat  (ps2_dat),
    .key_ascii(key_ascii),
    .key_count(key_count),
    .key_valid(key_valid),
    .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       is_err;
    int       ascii;
    int       count;
  } exp_t;

  exp_t exp_q[$];
  int   tests  = 0;
  int   failed = 0;

  // keyboard-level reference state
  bit m_brk, m_ext;
  bit m_held[4];
  int m_cnt[4];
  int m_last_ascii, m_last_count;
  int ascii_tab[4] = '{97, 100, 119, 115};

  function automatic int key_idx(input logic [7:0] c);
    case (c)
      8'h1C:   return 0;
      8'h23:   return 1;
      8'h1D:   return 2;
      8'h1B:   return 3;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    m_brk = 0; m_ext = 0;
    for (int i = 0; i < 4; i++) begin m_held[i] = 0; m_cnt[i] = 0; end
    m_last_ascii = 0; m_last_count = 0;
    exp_q.delete();
  endtask

  task automatic push_err();
    exp_t e;
    e.is_err = 1; e.ascii = m_last_ascii; e.count = m_last_count;
    exp_q.push_back(e);
  endtask

  task automatic model_byte(input logic [7:0] b, input bit bad);
    exp_t e;
    int   k;
    bit   was_brk, was_ext;
    if (bad) begin
      push_err();
      return;
    end
    if (b == 8'hF0) begin m_brk = 1; return; end
    if (b == 8'hE0) begin m_ext = 1; return; end
    was_brk = m_brk; was_ext = m_ext;
    m_brk = 0; m_ext = 0;
    k = key_idx(b);
    if (was_ext || k < 0) return;
    if (was_brk) begin
      m_held[k] = 0;
    end else if (!m_held[k]) begin
      m_held[k] = 1;
      if (m_cnt[k] < 255) m_cnt[k]++;
      m_last_ascii = ascii_tab[k];
      m_last_count = m_cnt[k];
      e.is_err = 0; e.ascii = m_last_ascii; e.count = m_last_count;
      exp_q.push_back(e);
    end
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_dat = bits[i];
      repeat (HALF) @(posedge clk);
      #2 ps2_clk = 1'b0;
      repeat (HALF) @(posedge clk);
      #2 ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic par;
    par = (~^b) ^ bad_par;
    model_byte(b, bad_par | bad_stop);
    send_bits({~bad_stop, par, b, 1'b0}, 11);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    repeat (10) @(posedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL drain_%s: %0d events still pending, required 0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_zero(input string tag);
    @(negedge clk);
    tests++;
    if (key_ascii !== 8'd0 || key_count !== 8'd0 || key_valid !== 1'b0 || frame_err !== 1'b0) begin
      failed++;
      $display("FAIL %s: ascii=%0d count=%0d valid=%0b err=%0b, required all 0",
               tag, key_ascii, key_count, key_valid, frame_err);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (key_valid || frame_err)) begin
      tests++;
      if (key_valid && frame_err) begin
        failed++;
        $display("FAIL strobe_overlap: key_valid=1 frame_err=1, required at most one");
      end else if (exp_q.size() == 0) begin
        failed++;
        $display("FAIL unexpected_event: valid=%0b err=%0b ascii=%0d count=%0d, required no event",
                 key_valid, frame_err, key_ascii, key_count);
      end else begin
        e = exp_q.pop_front();
        if (e.is_err != frame_err || e.ascii != int'(key_ascii) || e.count != int'(key_count)) begin
          failed++;
          $display("FAIL out_event: got err=%0b ascii=%0d count=%0d, required err=%0b ascii=%0d count=%0d",
                   frame_err, key_ascii, key_count, e.is_err, e.ascii, e.count);
        end
      end
    end
  end

  initial begin
    logic [7:0] b;
    int         sel;
    rst_n   = 1'b0;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    model_reset();
    repeat (5) @(posedge clk);
    check_zero("reset_outputs");
    #2 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #2;

    // stray edge with data high is a bad start bit
    push_err();
    send_bits(11'h7FF, 1);
    wait_drain("start_err");

    send_frame(8'h1C, 0, 0);
    wait_drain("first_key");

    send_frame(8'h23, 0, 0);
    send_frame(8'h23, 0, 0);
    send_frame(8'h23, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h23, 0, 0);
    send_frame(8'h23, 0, 0);
    wait_drain("typematic");

    send_frame(8'h1D, 1, 0);
    send_frame(8'h1D, 0, 1);
    wait_drain("bad_parity_stop");

    push_err();
    send_bits({6'h3F, 5'b10110}, 5);
    repeat (TMO + 20) @(posedge clk);
    #2;
    send_frame(8'h1B, 0, 0);
    wait_drain("timeout");

    send_frame(8'hE0, 0, 0);
    send_frame(8'h1B, 0, 0);
    send_frame(8'hE0, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h1B, 0, 0);
    send_frame(8'h5A, 0, 0);
    wait_drain("extended");

    for (int i = 0; i < 80; i++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0: b = 8'h1C;
        1: b = 8'h23;
        2: b = 8'h1D;
        3: b = 8'h1B;
        4, 5: b = 8'hF0;
        6: b = 8'hE0;
        default: b = 8'($urandom_range(0, 255));
      endcase
      send_frame(b, ($urandom_range(0, 9) == 0), ($urandom_range(0, 14) == 0));
    end
    wait_drain("random");

    send_frame(8'hF0, 0, 0);
    send_frame(8'h1C, 0, 0);
    send_frame(8'h1C, 0, 0);
    wait_drain("pre_reset");
    send_bits({6'h3F, 5'b11000}, 5);
    #3 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    check_zero("midframe_reset");
    model_reset();
    #2 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    send_frame(8'h1C, 0, 0);
    wait_drain("post_reset");

    send_frame(8'hF0, 0, 0);
    send_frame(8'h1C, 0, 0);
    for (int i = 0; i < 256; i++) begin
      send_frame(8'h1C, 0, 0);
      send_frame(8'hF0, 0, 0);
      send_frame(8'h1C, 0, 0);
    end
    send_frame(8'hE0, 0, 0);
    send_frame(8'h1C, 0, 0);
    wait_drain("saturation");

    @(negedge clk);
    tests++;
    if (int'(key_count) != m_last_count || key_count !== 8'd255 || int'(key_ascii) != m_last_ascii) begin
      failed++;
      $display("FAIL saturated_hold: ascii=%0d count=%0d, required ascii=%0d count=%0d",
               key_ascii, key_count, m_last_ascii, m_last_count);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
